multibyte_add_sequencer: RTL and testbench
==========================================

// Module: multibyte_add_sequencer
// PURPOSE
//   Adds two NBYTES-wide operands by time-sharing one eight_bit_adder, one byte per cycle, LSB byte first.
//   Carry between bytes is held in a register.
//   Sits between a requester (start/done handshake) and the 8-bit adder datapath.
//   Trades latency for area against a full-width adder.
// PARAMETERS
//   NBYTES  4  operand width in bytes; legal range >= 1
// PORTS
//   clk    in   1           single clock, rising-edge
//   rst    in   1           asynchronous, active-high reset
//   start  in   1           request; sampled only in IDLE
//   a      in   8*NBYTES    operand A; latched when start is accepted
//   b      in   8*NBYTES    operand B; latched when start is accepted
//   cin    in   1           carry-in to byte 0; latched when start is accepted
//   busy   out  1           high when state != IDLE
//   done   out  1           one-cycle pulse; sum/cout valid
//   sum    out  8*NBYTES    result; holds its value after done until the next accepted start
//   cout   out  1           carry out of the MS byte; holds like sum
// BEHAVIOUR
//   Reset (async, any state):
//     state=IDLE; idx=0; carry reg=0; operand regs=0.
//     busy=0, done=0, sum=0, cout=0.
//   FSM states: IDLE -> ADD -> DONE -> IDLE. All outputs are registered.
//   IDLE:
//     - start=1 at an edge -> latch a, b, cin; clear sum to 0; idx=0; carry=cin; go to ADD.
//     - start=0 -> stay in IDLE.
//   ADD:
//     - Each edge: adder A=a_q[8*idx+:8], B=b_q[8*idx+:8], Cin=carry.
//     - sum[8*idx+:8] <= Sum; carry <= Carry; idx <= idx+1.
//     - At the edge with idx==NBYTES-1: cout <= Carry; done <= 1; go to DONE.
//   DONE:
//     - done=1 for exactly this one cycle.
//     - Next edge: done <= 0; go to IDLE. No stall state.
//   Latency:
//     - Start-accept edge to done-high edge is NBYTES+1 edges.
//     - Back-to-back start is accepted at the first IDLE edge, so throughput is one result per NBYTES+2 cycles.
//   start while busy (ADD or DONE) is ignored and not queued. The in-flight result is unaffected.
//   Operand inputs may change after acceptance without effect.
//   Arithmetic:
//     - Unsigned modulo 2^(8*NBYTES); cout is the true carry out.
//     - idx width = max(1, $clog2(NBYTES)). idx never exceeds NBYTES-1 and does not wrap.
//   NBYTES=1: a single ADD cycle, equivalent to one eight_bit_adder op plus 2 cycles of handshake.
//   Reset mid-operation: the operation is aborted and outputs clear at once. The next start after release is treated as fresh.
//   sum bytes above idx read 0 while in ADD. Only done qualifies the result.
// STRUCTURE
//   Shared package/include: BYTE_W=8; state encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_DONE=2'd2 (2'd3 unused; decodes to IDLE).
//   One sub-module: the existing eight_bit_adder, instantiated once (ports A, B, Cin, Sum, Carry).
//   Everything else stays in this module: FSM, idx counter, operand, carry and sum registers.
// TESTING (NBYTES=4 unless stated)
//   1. rst=1 from time 0 -> busy=0, done=0, sum=0, cout=0. Release rst, start=0 for 10 cycles -> outputs unchanged.
//   2. a=32'h0000_0012, b=32'h0000_0023, cin=0, start pulse -> busy for 5 cycles.
//      done pulses once, NBYTES+1 edges after acceptance. sum=32'h0000_0035, cout=0.
//   3. a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0 -> sum=0, cout=1.
//      Also a=32'h0000_00AF, b=32'h01, cin=1 -> sum=32'h0000_00B1, cout=0.
//   4. Accept a=32'h1234_5678, b=32'h1111_1111, then raise start with a=b=32'hFFFF_FFFF in ADD and again in DONE.
//      -> Single done, sum=32'h2345_6789. Second start accepted only in IDLE.
//   5. rst pulse during 2nd ADD cycle -> busy, done, sum and cout go to 0 immediately.
//      After release, a=32'h8000_0000, b=32'h8000_0000 -> sum=0, cout=1.
//   6. NBYTES=1: a=8'hFF, b=8'h01, cin=1 -> done 2 edges after accept, sum=8'h01, cout=1.
//      Then 100 random vectors vs. {cout,sum}==a+b+cin.

Source files
------------

// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared constants, state encoding and sizing helper for the byte-serial adder sequencer.
package multibyte_add_sequencer_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte index counter width; a single-byte operand still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Requester-side start/done handshake plus operand and result buses.
interface multibyte_add_sequencer_if #(parameter int NBYTES = 4);

  logic                  start;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/multibyte_add_sequencer_adder.sv
// Existing 8-bit ripple datapath: one byte plus carry-in, combinational.
module eight_bit_adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Carry
);

  assign {Carry, Sum} = 9'(A) + 9'(B) + 9'(Cin);

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Adds two NBYTES-wide operands one byte per cycle, LSB first, through a single 8-bit adder.
// start is only sampled in IDLE; done pulses one cycle and sum/cout hold until the next accepted start.
module multibyte_add_sequencer
  import multibyte_add_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  multibyte_add_sequencer_if.slave bus
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               carry_q;
  logic               cout_q;

  logic [BYTE_W-1:0]  add_a;
  logic [BYTE_W-1:0]  add_b;
  logic [BYTE_W-1:0]  add_s;
  logic               add_c;

  assign add_a = a_q[BYTE_W*idx +: BYTE_W];
  assign add_b = b_q[BYTE_W*idx +: BYTE_W];

  eight_bit_adder u_adder (
    .A     (add_a),
    .B     (add_b),
    .Cin   (carry_q),
    .Sum   (add_s),
    .Carry (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = bus.start ? ST_ADD : ST_IDLE;
      ST_ADD:  state_nxt = (idx == LAST) ? ST_DONE : ST_ADD;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            idx     <= '0;
          end
        end
        ST_ADD: begin
          sum_q[BYTE_W*idx +: BYTE_W] <= add_s;
          carry_q                     <= add_c;
          // idx parks on the last byte rather than wrapping.
          if (idx == LAST) cout_q <= add_c;
          else             idx    <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == ST_ADD) || (state == ST_DONE);
  assign bus.done = (state == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Randomized and directed checks of the byte-serial adder at NBYTES=4 and NBYTES=1 against a + b + cin.
module tb_multibyte_add_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multibyte_add_sequencer_if #(.NBYTES(4)) bus4 ();
  multibyte_add_sequencer_if #(.NBYTES(1)) bus1 ();

  multibyte_add_sequencer #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  multibyte_add_sequencer #(.NBYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 4-byte operation. With poke set, start is held high with all-ones operands
  // through ADD and DONE, and must be ignored.
  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic c,
                     input bit poke, input string tag);
    logic [32:0] exp;
    int n;
    int busy_n;
    exp = 33'(a) + 33'(b) + 33'(c);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = c; bus4.start = 1'b1;
    @(posedge clk); #1;
    if (poke) begin
      bus4.a = 32'hFFFF_FFFF; bus4.b = 32'hFFFF_FFFF; bus4.cin = 1'b1;
    end else begin
      bus4.start = 1'b0;
      bus4.a = $urandom; bus4.b = $urandom; bus4.cin = 1'($urandom);
    end
    n = 1; busy_n = 0;
    while (!bus4.done && n < 20) begin
      busy_n += int'(bus4.busy);
      @(posedge clk); #1;
      n++;
    end
    busy_n += int'(bus4.busy);
    chk({tag, "_lat"},  64'(n), 64'(5));
    chk({tag, "_sum"},  64'(bus4.sum), 64'(exp[31:0]));
    chk({tag, "_cout"}, 64'(bus4.cout), 64'(exp[32]));
    @(posedge clk); #1;
    bus4.start = 1'b0;
    chk({tag, "_done_pulse"}, {62'd0, bus4.done, bus4.busy}, 64'd0);
    chk({tag, "_busy_cyc"}, 64'(busy_n), 64'(5));
    if (poke) begin
      busy_n = 0;
      repeat (3) begin
        @(posedge clk); #1;
        busy_n += int'(bus4.busy) + int'(bus4.done);
      end
      chk({tag, "_ignored"}, 64'(busy_n), 64'd0);
      chk({tag, "_hold"}, {31'd0, bus4.cout, bus4.sum}, 64'(exp));
    end
  endtask

  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    logic [8:0] exp;
    int n;
    exp = 9'(a) + 9'(b) + 9'(c);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = c; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus1.a = 8'($urandom); bus1.b = 8'($urandom);
    n = 1;
    while (!bus1.done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(2));
    chk({tag, "_res"}, {55'd0, bus1.cout, bus1.sum}, 64'(exp));
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'd0, bus1.done, bus1.busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int bad_idle;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    #2;
    chk("reset_out", {29'd0, bus4.busy, bus4.done, bus4.cout, bus4.sum}, 64'd0);
    chk("reset_out1", {53'd0, bus1.busy, bus1.done, bus1.cout, bus1.sum}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    bad_idle = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} != '0) bad_idle++;
    end
    chk("idle_quiet", 64'(bad_idle), 64'd0);

    op4(32'h0000_0012, 32'h0000_0023, 1'b0, 1'b0, "basic");
    op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "wrap");
    op4(32'h0000_00AF, 32'h0000_0001, 1'b1, 1'b0, "cin");
    op4(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, "busy_start");

    // Abort during the second ADD cycle.
    @(negedge clk);
    bus4.a = 32'h1234_5678; bus4.b = 32'h1111_1111; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_out", {29'd0, bus4.busy, bus4.done, bus4.cout, bus4.sum}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op4(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      op4(ra, rb, 1'($urandom), 1'b0, "rand4");
    end

    op1(8'hFF, 8'h01, 1'b1, "nb1");
    for (int i = 0; i < 100; i++)
      op1(8'($urandom), 8'($urandom), 1'($urandom), "rand1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
